robot_controller: RTL and testbench

Wall-following controller on the robot side of the world/robot sensor interface. The world drives the robot's `clock` and sensor bits `head`, `left`, `under` and `barrier`. This block returns one registered action per decision: `front`, `turn` or `remove`. It navigates the pipe map with a left-hand rule, clears trash blocking its path, and halts permanently on the target cell.

---
 rtl/robot_controller.sv | 118 +++++++++++
 tb/tb_robot_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/robot_controller.sv
// Wall-following robot controller: left-hand rule, trash removal, halt on target.
// Ports: clock/reset, sensors head/left/under/barrier, actions front/turn/remove.
module robot_controller #(
  parameter int REMOVE_CYCLES = 3,
  parameter int RTURN_CYCLES  = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic head,
  input  logic left,
  input  logic under,
  input  logic barrier,
  output logic front,
  output logic turn,
  output logic remove
);

  typedef enum logic [2:0] {
    INIT,
    DECIDE,
    FWD,
    TURN_L,
    TURN_R,
    REMOVE,
    HALT
  } state_t;

  localparam logic [1:0] RT_LAST = 2'(RTURN_CYCLES - 1);
  localparam logic [1:0] RM_LAST = 2'(REMOVE_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic       follow;
  logic       follow_nx;
  logic       jtl;
  logic       jtl_nx;
  logic [1:0] cnt;
  logic [1:0] cnt_nx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= INIT;
      follow <= 1'b0;
      jtl    <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      state  <= state_nx;
      follow <= follow_nx;
      jtl    <= jtl_nx;
      cnt    <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    follow_nx = follow;
    jtl_nx    = jtl;
    cnt_nx    = cnt;
    unique case (state)
      INIT: state_nx = DECIDE;
      DECIDE: begin
        cnt_nx = 2'd0;
        if (under) begin
          state_nx = HALT;
        end else if (barrier) begin
          state_nx = REMOVE;
        end else if (!follow && !left) begin
          // No wall yet: run straight until one shows up.
          if (!head) begin
            state_nx = FWD;
          end else begin
            state_nx  = TURN_R;
            follow_nx = 1'b1;
          end
        end else begin
          // Wall acquired (possibly this very cycle via left).
          follow_nx = 1'b1;
          if (!left && !jtl) begin
            state_nx = TURN_L;
            jtl_nx   = 1'b1;
          end else if (!head) begin
            state_nx = FWD;
            jtl_nx   = 1'b0;
          end else begin
            state_nx = TURN_R;
            jtl_nx   = 1'b0;
          end
        end
      end
      FWD:    state_nx = DECIDE;
      TURN_L: state_nx = DECIDE;
      TURN_R: begin
        if (cnt == RT_LAST) begin
          state_nx = DECIDE;
          cnt_nx   = 2'd0;
        end else begin
          cnt_nx = cnt + 2'd1;
        end
      end
      REMOVE: begin
        if (cnt == RM_LAST) begin
          state_nx = DECIDE;
          cnt_nx   = 2'd0;
        end else begin
          cnt_nx = cnt + 2'd1;
        end
      end
      HALT:    state_nx = HALT;
      default: state_nx = INIT;
    endcase
  end

  // Moore decode: async reset clears the actions without a clock edge.
  assign front  = (state == FWD);
  assign turn   = (state == TURN_L) || (state == TURN_R);
  assign remove = (state == REMOVE);

endmodule

// File: tb/tb_robot_controller.sv
// Bench for robot_controller: directed vector table, corner sequences,
// and random sensors against an action-queue reference model.
module tb_robot_controller;

  localparam int NREM = 3;
  localparam int NRT  = 3;
  localparam logic [2:0] O0 = 3'b000;
  localparam logic [2:0] OF = 3'b100;
  localparam logic [2:0] OT = 3'b010;
  localparam logic [2:0] OR = 3'b001;

  logic clock = 1'b0;
  logic reset;
  logic head, left, under, barrier;
  logic front, turn, remove;

  int checks = 0;
  int failures = 0;

  robot_controller #(
    .REMOVE_CYCLES(NREM),
    .RTURN_CYCLES (NRT)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .head   (head),
    .left   (left),
    .under  (under),
    .barrier(barrier),
    .front  (front),
    .turn   (turn),
    .remove (remove)
  );

  always #5 clock = ~clock;

  function automatic logic [2:0] outs();
    return {front, turn, remove};
  endfunction

  task automatic chk(input string nm, input logic [2:0] req);
    logic [2:0] act;
    act = outs();
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got ftr=%b want ftr=%b t=%0t",
               nm, act, req, $time);
    end
  endtask

  task automatic sens(input logic h, input logic l,
                      input logic u, input logic b);
    head = h; left = l; under = u; barrier = b;
  endtask

  // Entered and left at 1 time unit after a posedge, DUT in DECIDE.
  task automatic apply(input string nm, input logic h, input logic l,
                       input logic u, input logic b,
                       input logic [2:0] exp, input int len);
    chk({nm, "_decide"}, O0);
    sens(h, l, u, b);
    for (int i = 0; i < len; i++) begin
      @(posedge clock); #1;
      chk(nm, exp);
    end
    sens(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
  endtask

  task automatic rand_sens();
    logic h;
    h = ($urandom % 3) == 0;
    sens(h, 1'($urandom % 2), 1'($urandom % 150 == 0),
         !h && ($urandom % 8 == 0));
  endtask

  // Reference model: a queue of per-cycle action vectors that is refilled
  // from the decision rules whenever the robot is waiting to decide.
  logic [2:0] m_q[$];
  bit m_dec, m_halt, m_follow, m_jtl;

  function automatic void m_reset();
    m_q.delete();
    m_dec = 0; m_halt = 0; m_follow = 0; m_jtl = 0;
  endfunction

  function automatic void m_push(input logic [2:0] v, input int n);
    for (int i = 0; i < n; i++) m_q.push_back(v);
  endfunction

  function automatic void m_decide(input logic h, input logic l,
                                   input logic u, input logic b);
    if (u) m_halt = 1;
    else if (b) m_push(OR, NREM);
    else if (!m_follow && !l) begin
      if (!h) m_push(OF, 1);
      else begin m_push(OT, NRT); m_follow = 1; end
    end else begin
      m_follow = 1;
      if (!l && !m_jtl) begin m_push(OT, 1); m_jtl = 1; end
      else if (!h) begin m_push(OF, 1); m_jtl = 0; end
      else begin m_push(OT, NRT); m_jtl = 0; end
    end
  endfunction

  // Called at each posedge; returns the actions expected after it.
  function automatic logic [2:0] m_step(input logic h, input logic l,
                                        input logic u, input logic b);
    if (m_halt) return O0;
    if (m_dec) begin
      m_dec = 0;
      m_decide(h, l, u, b);
      if (m_halt) return O0;
    end
    if (m_q.size() > 0) return m_q.pop_front();
    m_dec = 1;
    return O0;
  endfunction

  typedef struct {
    string      nm;
    logic       h, l, u, b;
    logic [2:0] exp;
    int         len;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [2:0] e;
    int hcnt;
    tbl[0]  = '{"fwd_open1",   0, 0, 0, 0, OF, 1};
    tbl[1]  = '{"fwd_open2",   0, 0, 0, 0, OF, 1};
    tbl[2]  = '{"acq_fwd",     0, 1, 0, 0, OF, 1};
    tbl[3]  = '{"left_turn",   0, 0, 0, 0, OT, 1};
    tbl[4]  = '{"jtl_fwd",     0, 0, 0, 0, OF, 1};
    tbl[5]  = '{"left_turn2",  0, 0, 0, 0, OT, 1};
    tbl[6]  = '{"corner_rt",   1, 1, 0, 0, OT, NRT};
    tbl[7]  = '{"trash1",      0, 0, 0, 1, OR, NREM};
    tbl[8]  = '{"trash2",      0, 0, 0, 1, OR, NREM};
    tbl[9]  = '{"after_trash", 0, 1, 0, 0, OF, 1};
    tbl[10] = '{"blind_left",  1, 0, 0, 0, OT, 1};
    tbl[11] = '{"jtl_rt",      1, 0, 0, 0, OT, NRT};

    reset = 1'b1;
    sens(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1 chk("reset_state", O0);
    @(negedge clock) reset = 1'b0;
    #1 chk("init", O0);
    @(posedge clock); #1;

    foreach (tbl[i])
      apply(tbl[i].nm, tbl[i].h, tbl[i].l, tbl[i].u, tbl[i].b,
            tbl[i].exp, tbl[i].len);

    // Target wins over trash; halt ignores everything afterwards.
    chk("halt_decide", O0);
    sens(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 24; i++) begin
      @(posedge clock); #1;
      chk("halt_hold", O0);
      rand_sens();
    end
    reset = 1'b1;
    #3 reset = 1'b0;
    sens(1'b0, 1'b0, 1'b0, 1'b0);
    chk("halt_reset", O0);
    @(posedge clock); #1;
    apply("restart_fwd", 0, 0, 0, 0, OF, 1);
    apply("reacq_fwd", 0, 1, 0, 0, OF, 1);

    // Async reset mid-removal, follow set beforehand.
    chk("rm_decide", O0);
    sens(1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clock); #1;
    chk("rm_c1", OR);
    sens(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    chk("rm_c2", OR);
    #2 reset = 1'b1;
    #1 chk("rm_async_drop", O0);
    #2 reset = 1'b0;
    @(posedge clock); #1;
    apply("post_rst_fwd", 0, 0, 0, 0, OF, 1);

    // Random phase against the model.
    reset = 1'b1;
    #3 reset = 1'b0;
    m_reset();
    hcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (($urandom % 120 == 0) || hcnt > 30) begin
        reset = 1'b1;
        #1 chk("rnd_reset", O0);
        #2 reset = 1'b0;
        m_reset();
        hcnt = 0;
      end
      rand_sens();
      @(posedge clock);
      e = m_step(head, left, under, barrier);
      #1 chk("rnd", e);
      if (m_halt) hcnt++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
